// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice: parity modes, FSM states
// and the standard baud divisors for the 37.5 MHz build.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int DIV_19200  = 1953;
    localparam int DIV_115200 = 325;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// CPU-side polling interface of the receiver: head-entry view, flags and
// the done handshake.
interface uart_rx_if #(parameter int DATA_BITS = 8);

    logic                 done;
    logic                 rdy;
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
    logic                 ovr;
    logic                 busy;

    modport master (output done, input rdy, data, perr, ferr, ovr, busy);
    modport slave  (input done, output rdy, data, perr, ferr, ovr, busy);

endinterface

// File: rtl/uart_fifo.sv
// Small synchronous FIFO; head entry is read combinationally from storage.
// Push into a full FIFO is accepted only when a pop frees a slot that cycle.
module uart_fifo #(
    parameter int W  = 10,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + AW'(1);
            end
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// RS232 receiver: runtime baud divisor, configurable width/parity, start-bit
// glitch rejection, framing/parity checks and a small receive FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV_W     = 12,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int FIFO_AW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RxD,
    input  logic [DIV_W-1:0] div,
    uart_rx_if.slave         bus
);

    localparam int BC_W = $clog2(DATA_BITS);
    localparam int EW   = DATA_BITS + 2;

    state_t               state_q, state_d;
    logic                 s0, s1;
    logic [DIV_W-1:0]     div_q, tick;
    logic [BC_W-1:0]      bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_n;
    logic                 start_edge, mid, bit_end, last_bit;
    logic                 shift_en, par_en, push, pop;
    logic                 full, empty, ovr_q;
    logic [EW-1:0]        head;

    assign start_edge = s1 & ~s0;
    assign mid        = (tick == (div_q >> 1));
    assign bit_end    = (tick == div_q);
    assign last_bit   = (bitcnt == BC_W'(DATA_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            s0 <= RxD;
            s1 <= s0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Leaving at the stop midpoint leaves half a bit of slack to catch the
    // next start edge of a back-to-back frame from a slightly slow sender.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        par_en   = 1'b0;
        push     = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (start_edge) state_d = ST_START;
            ST_START: begin
                if (mid && s1)    state_d = ST_IDLE;
                else if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                shift_en = mid;
                if (bit_end && last_bit)
                    state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                par_en = mid;
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (mid) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            tick   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            perr_n <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                tick <= '0;
                if (start_edge) div_q <= div;
            end else begin
                tick <= bit_end ? '0 : tick + DIV_W'(1);
            end
            if (state_q == ST_START) begin
                bitcnt <= '0;
                perr_n <= 1'b0;
            end else if (state_q == ST_DATA && bit_end) begin
                bitcnt <= bitcnt + BC_W'(1);
            end
            if (shift_en) shreg <= {s1, shreg[DATA_BITS-1:1]};
            if (par_en)   perr_n <= s1 ^ (^shreg) ^ (PARITY == PAR_ODD);
        end
    end

    assign pop = bus.done & ~empty;

    uart_fifo #(.W(EW), .AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({perr_n, ~s1, shreg}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // A dropped push wins over a clearing pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      ovr_q <= 1'b0;
        else if (push & full & ~pop)  ovr_q <= 1'b1;
        else if (pop)                 ovr_q <= 1'b0;
    end

    assign bus.rdy  = ~empty;
    assign bus.data = head[DATA_BITS-1:0];
    assign bus.ferr = head[DATA_BITS];
    assign bus.perr = head[DATA_BITS+1];
    assign bus.ovr  = ovr_q;
    assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Parametrised RS232 receiver and successor to the fixed 8N1 two-rate receiver. Features:
- Runtime baud divisor.
- Configurable data width and parity.
- Start-bit glitch rejection.
- Stop-bit framing and parity checks.
- Small receive FIFO with overrun detection.

It sits on the I/O bus beside the transmitter. The CPU polls rdy, reads data and error flags, then pulses done.

Parameters:
DIV_W, 12, width of the baud divisor port.
DATA_BITS, 8, data bits per frame (5..9).
PARITY, 0, 0 = none, 1 = even, 2 = odd.
FIFO_AW, 2, FIFO address width (depth = 2**FIFO_AW = 4).

Ports:
clk  in  1  system clock (37.5 MHz in current build)
rst  in  1  reset, asynchronous, active-high
RxD  in  1  serial line, idle high, asynchronous to clk
div  in  DIV_W  bit period minus 1 in clk cycles (325 -> 115200 bps, 1953 -> 19200 bps)
done  in  1  one-cycle pulse: head entry consumed
rdy  out  1  FIFO non-empty
data  out  DATA_BITS  head entry data, LSB = first received bit
perr  out  1  head entry parity error
ferr  out  1  head entry framing error (stop bit sampled low)
ovr  out  1  sticky overrun flag
busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset (async, rst=1):
  - State IDLE; counters, shift register, FIFO pointers and storage cleared.
  - rdy=0, data=0, perr=0, ferr=0, ovr=0, busy=0.
  - Synchroniser flops set to 1 (idle line).
  - Reset mid-frame discards the partial frame.
- Synchroniser: s0<=RxD, s1<=s0. Start edge = s1 & ~s0.
- Timing:
  - div is captured into div_q on the start edge. Changes to div mid-frame have no effect.
  - tick counts 0..div_q, then wraps to 0, giving a bit period of div_q+1 clocks.
  - mid = (tick == div_q>>1); end = (tick == div_q).
- States:
  - IDLE: on start edge -> START, tick=0.
  - START: at mid, if s1=1 -> IDLE (glitch, nothing pushed); else continue. At end -> DATA, bitcnt=0.
  - DATA: at mid, shift s1 into MSB of shreg (LSB-first line order). At end, bitcnt+1; when bitcnt==DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
  - PARITY: at mid, perr_n = s1 ^ (^shreg) ^ (PARITY==2). At end -> STOP.
  - STOP: at mid, ferr_n = ~s1, push {perr_n, ferr_n, shreg}, -> IDLE.
- Returning to IDLE at the stop midpoint (not its end) allows resync to back-to-back frames and a half-bit clock mismatch.
- Framing error: entry is still pushed. If the line stays low, no new start edge occurs until it returns high.
- FIFO:
  - Head entry drives data/perr/ferr combinationally from storage.
  - rdy=1 the cycle after the push cycle (push registered).
  - done with rdy=1 pops the head. done with rdy=0 is ignored.
  - Push when full with no pop in the same cycle: entry dropped, ovr<=1.
  - Push and pop in the same cycle: both happen, count unchanged (including the full case).
  - ovr clears on any accepted done pulse; set takes priority over clear in the same cycle.
- Parity bit width: perr=0 always when PARITY=0.

Decomposition:
- Shared package uart_pkg: parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD; state encoding IDLE/START/DATA/PARITY/STOP; the standard divisor constants DIV_19200=1953 and DIV_115200=325 for 37.5 MHz.
- One sub-module: uart_fifo, a synchronous FIFO with width DATA_BITS+2, depth 2**FIFO_AW, push/pop/full/empty ports, async active-high reset. The same FIFO is reused by the future buffered transmitter.

Test Plan:
- div=325, 8N1: send 0xA5 -> rdy rises 1 cycle after stop midpoint; data=0xA5, perr=0, ferr=0. done pulse -> rdy=0.
- Low pulse of 100 clocks on RxD with div=325 -> no push; state back to IDLE at tick 162; rdy stays 0.
- PARITY=1, div=1953: send 0x03 with parity bit 1 -> perr=1. Same byte with parity bit 0 -> perr=0.
- Stop bit driven low on 0x5A -> entry pushed with ferr=1, data=0x5A.
- FIFO_AW=2: send 5 bytes 0x01..0x05 without done -> ovr=1; four done pulses read 0x01..0x04; ovr cleared after the first done.
- rst asserted at bit 4 of a frame, released, then 0x3C sent -> only 0x3C received, no errors.
- Back-to-back frames (stop of one directly followed by the next start) with RxD bit period 2% slower than div -> all bytes received correctly.
